// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, credit-limited imem requests, response FIFO, redirect flush.
// Optional combinational response bypass to decode when the FIFO is empty: define FETCH_BYPASS_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW:0]   DEPTH_C  = (CW + 1)'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   data_q [FIFO_DEPTH];
  logic [31:0]   data_d [FIFO_DEPTH];
  logic [31:0]   fpc_q  [FIFO_DEPTH];
  logic [31:0]   fpc_d  [FIFO_DEPTH];

  logic        credit_ok, req_fire, resp_fire, fifo_nonempty;
  logic        bypass, push, pop;
  logic [31:0] resp_pc;
  logic        unused_bits;

  assign unused_bits = ^redirect_pc[1:0];

  always_comb begin
    credit_ok      = ({1'b0, outst_q} + {1'b0, cnt_q}) < DEPTH_C;
    imem_req_valid = !reset && !redirect_valid && credit_ok;
    imem_req_addr  = pc_q;
    req_fire       = imem_req_valid && imem_req_ready;
    resp_fire      = imem_resp_valid && (outst_q != '0);
    // Oldest in-flight request sits outst_q words behind the next fetch PC.
    resp_pc        = pc_q - (32'(outst_q) << 2);
    fifo_nonempty  = (cnt_q != '0);
`ifdef FETCH_BYPASS_EN
    bypass = !reset && !redirect_valid && !fifo_nonempty && (drop_q == '0) && resp_fire;
`else
    bypass = 1'b0;
`endif
    instr_valid = fifo_nonempty || bypass;
    instr       = bypass ? imem_resp_data : (fifo_nonempty ? data_q[rd_ptr_q] : 32'h0);
    pc_out      = bypass ? resp_pc        : (fifo_nonempty ? fpc_q[rd_ptr_q]  : 32'h0);

    pop  = fifo_nonempty && instr_ready && !redirect_valid;
    push = resp_fire && (drop_q == '0) && !redirect_valid && !(bypass && instr_ready);

    pc_d     = pc_q;
    outst_d  = outst_q + CW'(req_fire) - CW'(resp_fire);
    drop_d   = drop_q;
    cnt_d    = cnt_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    data_d   = data_q;
    fpc_d    = fpc_q;

    if (redirect_valid) begin
      pc_d     = {redirect_pc[31:2], 2'b00};
      drop_d   = outst_q - CW'(resp_fire);
      cnt_d    = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (req_fire) pc_d = pc_q + 32'd4;
      if (resp_fire && (drop_q != '0)) drop_d = drop_q - 1'b1;
      if (push) begin
        data_d[wr_ptr_q] = imem_resp_data;
        fpc_d[wr_ptr_q]  = resp_pc;
        wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      outst_q  <= '0;
      drop_q   <= '0;
      cnt_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      pc_q     <= pc_d;
      outst_q  <= outst_d;
      drop_q   <= drop_d;
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
    data_q <= data_d;
    fpc_q  <= fpc_d;
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with an in-order latency memory model.
module tb_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0100;
`ifdef FETCH_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic        instr_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .instr_valid(instr_valid), .instr(instr), .pc_out(pc_out), .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  int          n_vec = 0, n_err = 0;
  int          now = 0, n_req = 0, n_out = 0, mem_lat = 1;
  logic        mem_rdy = 1'b1;
  logic [31:0] mem_q[$];
  int          mem_t[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;
  logic        lat_probe = 1'b0, want_first = 1'b0, saw_zero = 1'b0;
  logic        last_req_valid, last_resp;
  logic [31:0] last_req_addr, first_pc;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
    instr_ready = 1'b0; redirect_valid = 1'b0;
    mem_q.delete(); mem_t.delete(); exp_q.delete();
    @(posedge clk); #1;
    chk_eq("rst_instr_valid", instr_valid, 0);
    chk_eq("rst_instr", instr, 0);
    chk_eq("rst_pc_out", pc_out, 0);
    chk_eq("rst_req_valid", imem_req_valid, 0);
    reset = 1'b0; exp_pc = RST_PC;
    #1;
    chk_eq("first_req_valid", imem_req_valid, 1);
    chk_eq("first_req_addr", imem_req_addr, RST_PC);
  endtask

  // One clock: drive this cycle's inputs, then account for what the next edge commits.
  task automatic cycle(input logic dec_rdy, input logic redir, input logic [31:0] rpc);
    logic [31:0] e;
    @(posedge clk); #1;
    now++;
    imem_req_ready = mem_rdy; instr_ready = dec_rdy;
    redirect_valid = redir; redirect_pc = rpc;
    if (mem_q.size() > 0 && mem_t[0] <= now) begin
      imem_resp_valid = 1'b1; imem_resp_data = ~mem_q[0];
    end else begin
      imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
    end
    #1;
    last_req_valid = imem_req_valid; last_req_addr = imem_req_addr; last_resp = imem_resp_valid;
    if (lat_probe && imem_resp_valid) begin
      chk_eq("resp_latency", instr_valid, BYP);
      lat_probe = 1'b0;
    end
    if (imem_resp_valid) begin
      void'(mem_q.pop_front()); void'(mem_t.pop_front());
    end
    if (redir) begin
      chk_eq("redir_req_valid", imem_req_valid, 0);
      exp_q.delete();
      exp_pc = {rpc[31:2], 2'b00};
    end else begin
      if (instr_valid && instr_ready) begin
        if (exp_q.size() == 0) chk_eq("spurious_instr", instr_valid, 0);
        else begin
          e = exp_q.pop_front();
          chk_eq("pc_out", pc_out, e);
          chk_eq("instr", instr, ~e);
          if (want_first) begin first_pc = pc_out; want_first = 1'b0; end
        end
        n_out++;
      end
      if (imem_req_valid && imem_req_ready) begin
        chk_eq("req_addr", imem_req_addr, exp_pc);
        if (imem_req_addr == 32'h0) saw_zero = 1'b1;
        mem_q.push_back(imem_req_addr); mem_t.push_back(now + mem_lat);
        exp_q.push_back(exp_pc);
        exp_pc += 32'd4;
        n_req++;
      end
    end
  endtask

  task automatic drain();
    mem_rdy = 1'b0;
    for (int i = 0; i < 40 && (exp_q.size() != 0 || mem_q.size() != 0); i++) cycle(1'b1, 1'b0, 32'h0);
    chk_eq("drain_empty", exp_q.size(), 0);
    chk_eq("drain_mem_empty", mem_q.size(), 0);
    mem_rdy = 1'b1;
  endtask

  initial begin
    int base, seen;
    do_reset();
    // Streaming with single-cycle memory.
    lat_probe = 1'b1; mem_lat = 1;
    for (int i = 0; i < 14; i++) cycle(1'b1, 1'b0, 32'h0);
    chk_eq("lat_probe_done", lat_probe, 0);
    chk_eq("stream_progress", n_out >= 5, 1);
    drain();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0);
    drain();

    // Decode stalled: credit caps in-flight plus buffered at two.
    base = n_req;
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 32'h0);
    chk_eq("hold_reqs", n_req - base, 2);
    chk_eq("hold_req_valid", last_req_valid, 0);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 32'h0);
    drain();

    // Memory not ready: request holds.
    do_reset();
    mem_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 32'h0);
      chk_eq("stall_valid", last_req_valid, 1);
      chk_eq("stall_addr", last_req_addr, RST_PC);
    end
    mem_rdy = 1'b1;
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 32'h0);
    drain();

    // Redirect with two requests in flight.
    do_reset();
    mem_lat = 3;
    base = n_req;
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    chk_eq("inflight_reqs", n_req - base, 2);
    cycle(1'b1, 1'b1, 32'h0000_2002);
    mem_lat = 1; want_first = 1'b1;
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 32'h0);
    chk_eq("redir_first_pc", first_pc, 32'h0000_2000);
    drain();

    // Redirect coinciding with a response and a decode handshake.
    seen = 0;
    for (int i = 0; i < 12 && seen == 0; i++) begin
      cycle(1'b1, 1'b0, 32'h0);
      if (mem_q.size() > 0 && mem_t[0] <= now + 1 && exp_q.size() > 1) seen = 1;
    end
    chk_eq("overlap_setup", seen, 1);
    cycle(1'b1, 1'b1, 32'h0000_3000);
    chk_eq("overlap_resp", last_resp, 1);
    want_first = 1'b1;
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 32'h0);
    chk_eq("overlap_first_pc", first_pc, 32'h0000_3000);
    drain();

    // PC wrap at the top of the address space.
    cycle(1'b1, 1'b1, 32'hFFFF_FFFC);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 32'h0);
    chk_eq("wrap_seen_zero", saw_zero, 1);
    drain();

    // Reset in the middle of a stream.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 32'h0);
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 32'h0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
